// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the 16-bit register bank.
// The block tracks the destination registers of the last three issued instructions.
// From that history it drives the registered operand bypass selects mux_sel_A/mux_sel_B:
//    00 register file, 01 ans_ex, 10 ans_dm, 11 ans_wb.
// It stalls issue for exactly one cycle when an operand needs a load that is still in EX.
//
// Optional build macro:
//    FWD_R0_ZERO_EN - register 0 is hardwired zero. A slot that writes r0 never forwards
//                     and never causes a stall, but it still occupies its pipeline slot.

module fwd_hazard_ctrl #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [AW-1:0] id_ra,
   input  logic [AW-1:0] id_rb,
   input  logic          id_use_a,
   input  logic          id_use_b,
   input  logic [AW-1:0] id_rw,
   input  logic          id_we,
   input  logic          id_load,
   input  logic          flush,
   output logic          stall,
   output logic          issue,
   output logic [1:0]    mux_sel_A,
   output logic [1:0]    mux_sel_B
);

   // Slot tracker. Index 0 is S1 (youngest, now in EX), 1 is S2 (DM), 2 is S3 (WB).
   logic [2:0]    slot_v;
   logic [2:0]    slot_we;
   logic [2:0]    slot_load;
   logic [AW-1:0] slot_rw [3];

   // Slot-qualifies-as-producer flags, after the optional r0 rule
   logic [2:0]    slot_live;

   // Per-slot hits against the decode operands
   logic [2:0]    hit_a;
   logic [2:0]    hit_b;

   logic [1:0]    sel_a_next;
   logic [1:0]    sel_b_next;

   // Youngest hit wins: EX beats DM beats WB, so an older value is never chosen
   function automatic logic [1:0] pick_src(input logic [2:0] hits);
      logic [1:0] src;
      src = 2'b00;
      if (hits[0])
         src = 2'b01;
      else if (hits[1])
         src = 2'b10;
      else if (hits[2])
         src = 2'b11;
      return src;
   endfunction

`ifdef FWD_R0_ZERO_EN
   // With r0 hardwired to zero, a slot targeting r0 never produces a usable value
   always_comb begin
      slot_live = '0;
      for (int i = 0; i < 3; i++) begin
         slot_live[i] = |slot_rw[i];
      end
   end
`else
   // r0 is an ordinary register, so every slot is a candidate producer
   always_comb begin
      slot_live = 3'b111;
   end
`endif

   // Compare each tracked destination against the operands decode actually reads
   always_comb begin
      hit_a = '0;
      hit_b = '0;
      for (int i = 0; i < 3; i++) begin
         hit_a[i] = slot_v[i] & slot_we[i] & slot_live[i] & (slot_rw[i] == id_ra) & id_use_a;
         hit_b[i] = slot_v[i] & slot_we[i] & slot_live[i] & (slot_rw[i] == id_rb) & id_use_b;
      end
   end

   // A load in EX cannot feed decode yet; flush kills the instruction, so flush beats stall
   always_comb begin
      stall = id_valid & ~flush & slot_load[0] & (hit_a[0] | hit_b[0]);
      issue = id_valid & ~flush & ~stall;
   end

   // Next bypass selects, forced to register path whenever nothing issues
   always_comb begin
      sel_a_next = 2'b00;
      sel_b_next = 2'b00;
      if (issue) begin
         sel_a_next = pick_src(hit_a);
         sel_b_next = pick_src(hit_b);
      end
   end

   // Advance the slot history every edge and register the selects beside the bank reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v     <= '0;
         slot_we    <= '0;
         slot_load  <= '0;
         slot_rw[0] <= '0;
         slot_rw[1] <= '0;
         slot_rw[2] <= '0;
         mux_sel_A  <= 2'b00;
         mux_sel_B  <= 2'b00;
      end else begin
         slot_v[2]    <= slot_v[1];
         slot_we[2]   <= slot_we[1];
         slot_load[2] <= slot_load[1];
         slot_rw[2]   <= slot_rw[1];
         slot_v[1]    <= slot_v[0];
         slot_we[1]   <= slot_we[0];
         slot_load[1] <= slot_load[0];
         slot_rw[1]   <= slot_rw[0];
         slot_v[0]    <= issue;
         slot_we[0]   <= issue & id_we;
         slot_load[0] <= issue & id_load;
         slot_rw[0]   <= issue ? id_rw : '0;
         mux_sel_A    <= sel_a_next;
         mux_sel_B    <= sel_b_next;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl
// Directed and random stimulus for fwd_hazard_ctrl.
// Outputs are checked against a history model of the last three issued instructions,
// each tagged with its pipeline age. Honours FWD_R0_ZERO_EN the same way the design does.

module tb_fwd_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_ra;
   logic [4:0] id_rb;
   logic       id_use_a;
   logic       id_use_b;
   logic [4:0] id_rw;
   logic       id_we;
   logic       id_load;
   logic       flush;
   logic       stall;
   logic       issue;
   logic [1:0] mux_sel_A;
   logic [1:0] mux_sel_B;

   int vectors_applied = 0;
   int miscompares     = 0;

`ifdef FWD_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   // History of issued instructions: entry 0 issued one edge ago, 1 two ago, 2 three ago
   bit         hist_v  [3];
   bit         hist_we [3];
   bit         hist_ld [3];
   logic [4:0] hist_rw [3];

   fwd_hazard_ctrl #(.AW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_valid  (id_valid),
      .id_ra     (id_ra),
      .id_rb     (id_rb),
      .id_use_a  (id_use_a),
      .id_use_b  (id_use_b),
      .id_rw     (id_rw),
      .id_we     (id_we),
      .id_load   (id_load),
      .flush     (flush),
      .stall     (stall),
      .issue     (issue),
      .mux_sel_A (mux_sel_A),
      .mux_sel_B (mux_sel_B)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void clear_history();
      for (int i = 0; i < 3; i++) begin
         hist_v[i]  = 1'b0;
         hist_we[i] = 1'b0;
         hist_ld[i] = 1'b0;
         hist_rw[i] = 5'd0;
      end
   endfunction

   // Age (1..3) of the youngest instruction that wrote r, or 0 if none did
   function automatic int producer_age(input logic [4:0] r, input logic used);
      if (!used)
         return 0;
      if (R0_ZERO && r == 5'd0)
         return 0;
      for (int age = 0; age < 3; age++) begin
         if (hist_v[age] && hist_we[age] && hist_rw[age] == r)
            return age + 1;
      end
      return 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      vectors_applied++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one decode cycle starting just after a rising edge, check stall/issue mid-cycle,
   // then check the registered selects just after the next rising edge
   task automatic applyStimulus(input string tag,
                                input logic v, input logic [4:0] ra, input logic [4:0] rb,
                                input logic ua, input logic ub, input logic [4:0] rw,
                                input logic we, input logic ld, input logic fl);
      int  age_a;
      int  age_b;
      bit  exp_stall;
      bit  exp_issue;
      logic [1:0] exp_a;
      logic [1:0] exp_b;
      id_valid = v;
      id_ra    = ra;
      id_rb    = rb;
      id_use_a = ua;
      id_use_b = ub;
      id_rw    = rw;
      id_we    = we;
      id_load  = ld;
      flush    = fl;
      #3;
      age_a     = producer_age(ra, ua);
      age_b     = producer_age(rb, ub);
      exp_stall = v && !fl && hist_ld[0] && (age_a == 1 || age_b == 1);
      exp_issue = v && !fl && !exp_stall;
      exp_a     = exp_issue ? 2'(age_a) : 2'b00;
      exp_b     = exp_issue ? 2'(age_b) : 2'b00;
      checkOutput({tag, ".stall"}, {1'b0, stall}, {1'b0, exp_stall});
      checkOutput({tag, ".issue"}, {1'b0, issue}, {1'b0, exp_issue});
      @(posedge clk);
      #1;
      for (int i = 2; i > 0; i--) begin
         hist_v[i]  = hist_v[i-1];
         hist_we[i] = hist_we[i-1];
         hist_ld[i] = hist_ld[i-1];
         hist_rw[i] = hist_rw[i-1];
      end
      hist_v[0]  = exp_issue;
      hist_we[0] = exp_issue && we;
      hist_ld[0] = exp_issue && ld;
      hist_rw[0] = rw;
      checkOutput({tag, ".selA"}, mux_sel_A, exp_a);
      checkOutput({tag, ".selB"}, mux_sel_B, exp_b);
   endtask

   // Single linear sequence of directed steps followed by a random phase
   initial begin
      clear_history();
      rst_n    = 1'b0;
      id_valid = 1'b0;
      id_ra    = 5'd0;
      id_rb    = 5'd0;
      id_use_a = 1'b0;
      id_use_b = 1'b0;
      id_rw    = 5'd0;
      id_we    = 1'b0;
      id_load  = 1'b0;
      flush    = 1'b0;
      #2;
      checkOutput("reset.stall", {1'b0, stall}, 2'b00);
      checkOutput("reset.issue", {1'b0, issue}, 2'b00);
      checkOutput("reset.selA", mux_sel_A, 2'b00);
      checkOutput("reset.selB", mux_sel_B, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Distance 1, 2, 3 and 4 forwarding of r3 into operand A
      applyStimulus("add_r3_a",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      applyStimulus("sub_d1",    1, 5'd3, 5'd2, 1, 1, 5'd6, 1, 0, 0);
      applyStimulus("add_r3_b",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      applyStimulus("bubble1",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("sub_d2",    1, 5'd3, 5'd2, 1, 1, 5'd7, 1, 0, 0);
      applyStimulus("add_r3_c",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      applyStimulus("bubble2a",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("bubble2b",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("sub_d3",    1, 5'd3, 5'd2, 1, 1, 5'd8, 1, 0, 0);
      applyStimulus("add_r3_d",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      applyStimulus("bubble3a",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("bubble3b",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("bubble3c",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      applyStimulus("sub_d4",    1, 5'd3, 5'd2, 1, 1, 5'd9, 1, 0, 0);

      // Two producers of r4: the youngest must win on both operands
      applyStimulus("add_r4_old", 1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0);
      applyStimulus("add_r4_new", 1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0);
      applyStimulus("read_r4_ab", 1, 5'd4, 5'd4, 1, 1, 5'd10, 1, 0, 0);

      // Load-use on operand B: one stall, then issue selecting ans_dm
      applyStimulus("load_r5",    1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0);
      applyStimulus("use_r5_stl", 1, 5'd1, 5'd5, 1, 1, 5'd11, 1, 0, 0);
      applyStimulus("use_r5_iss", 1, 5'd1, 5'd5, 1, 1, 5'd11, 1, 0, 0);

      // Load that is not consumed does not stall
      applyStimulus("load_r12",   1, 5'd1, 5'd2, 1, 0, 5'd12, 1, 1, 0);
      applyStimulus("no_use_r12", 1, 5'd12, 5'd12, 0, 0, 5'd13, 1, 0, 0);

      // Flush beats the load-use stall
      applyStimulus("load_r5_f",  1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0);
      applyStimulus("flush_dep",  1, 5'd1, 5'd5, 1, 1, 5'd14, 1, 0, 1);

      // r0 destination followed by an r0 read
      applyStimulus("add_r0",     1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
      applyStimulus("read_r0",    1, 5'd0, 5'd0, 1, 1, 5'd15, 1, 0, 0);

      // Reset asserted mid-stall drops the stall immediately
      applyStimulus("load_r5_r",  1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0);
      id_valid = 1'b1;
      id_ra    = 5'd1;
      id_rb    = 5'd5;
      id_use_a = 1'b1;
      id_use_b = 1'b1;
      id_rw    = 5'd16;
      id_we    = 1'b1;
      id_load  = 1'b0;
      flush    = 1'b0;
      #3;
      checkOutput("pre_rst.stall", {1'b0, stall}, 2'b01);
      #1;
      rst_n = 1'b0;
      clear_history();
      #1;
      checkOutput("mid_rst.stall", {1'b0, stall}, 2'b00);
      checkOutput("mid_rst.selA", mux_sel_A, 2'b00);
      checkOutput("mid_rst.selB", mux_sel_B, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus("post_rst",   1, 5'd1, 5'd5, 1, 1, 5'd16, 1, 0, 0);

      // Random phase over a small register set so hits are frequent
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand",
                       ($urandom_range(0, 9) < 8),
                       5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)),
                       ($urandom_range(0, 9) < 8),
                       ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 19) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
